conv_accum: RTL and testbench
=============================

CONV_ACCUM -- requirements
Module: conv_accum

Interface
- REQ-001 SHALL have parameter WIDTH, default 9: operand half-width; data words are 2*WIDTH bits, sign-magnitude.
- REQ-002 SHALL have parameter TERMS, default 9: number of products summed per output (3x3 kernel); legal range is TERMS >= 1.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-005 SHALL have port in_valid, input, 1 bit: the upstream product word is valid.
- REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
- REQ-007 SHALL have port in_data, input, 2*WIDTH bits: product word; MSB is the sign (1 = negative), lower 2*WIDTH-1 bits are the magnitude.
- REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a completed sum.
- REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the sum.
- REQ-010 SHALL have port out_data, output, 2*WIDTH bits: the sign-magnitude sum of TERMS terms.
- REQ-011 SHALL have port out_overflow, output, 1 bit: a magnitude overflow occurred during this sum.

Function
- REQ-012 SHALL implement three states:
  - IDLE: acc = +0, count = 0.
  - ACCUM: at least one term taken.
  - HOLD: result presented.
- REQ-013 SHALL accept a term when in_valid && in_ready; in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- REQ-014 SHALL update the accumulator on each accepted term as acc <= acc + in_data, using sign-magnitude addition:
  - Equal signs: add the magnitudes; the result keeps the common sign.
  - Differing signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
- REQ-015 SHALL normalise a zero-magnitude result to sign 0, so that -0 is never stored or output.
- REQ-016 SHALL raise a carry out of the (2*WIDTH-1)-bit magnitude only on same-sign adds; this carry is an overflow event.
- REQ-017 SHALL count accepted terms; the state transitions are:
  - IDLE->ACCUM on the first accepted term.
  - On the TERMS-th accepted term: ->HOLD (when TERMS=1, IDLE->HOLD directly).
  - HOLD->IDLE on out_valid && out_ready.
- REQ-018 SHALL set latency as follows: out_valid rises the cycle after the TERMS-th term is accepted.
- REQ-019 SHALL keep out_data and out_overflow stable while out_valid=1 && out_ready=0.
- REQ-020 SHALL clear acc, count and the overflow flag on the out handshake; the next term is accepted no earlier than the following cycle.
- REQ-021 SHALL drive out_valid=0 outside HOLD; out_data and out_overflow then show the running accumulator value and flag.
- REQ-022 SHALL ignore in_data whenever in_ready=0; the term is neither consumed nor lost to upstream.

Reset
- REQ-023 SHALL, on rst, immediately set the state to IDLE, count=0, acc=+0, out_valid=0, out_data=0, out_overflow=0 and in_ready=0.
- REQ-024 SHALL bring in_ready to 1 on the first clock after rst deasserts.
- REQ-025 SHALL, on rst mid-sum or in HOLD, discard the partial or pending result.

Configuration
- REQ-026 SHALL, with macro CONV_ACCUM_SAT_EN defined, clamp the magnitude to all-ones on an overflow event and set out_overflow sticky until the handshake or reset.
- REQ-027 SHALL, without CONV_ACCUM_SAT_EN, drop the carry so the magnitude wraps modulo 2^(2*WIDTH-1), and tie out_overflow to 0.

Structure
- REQ-028 SHALL place the default WIDTH/TERMS constants and the state enum (IDLE, ACCUM, HOLD) in shared package conv_pkg.
- REQ-029 SHALL contain one combinational sub-module, conv_sm_add, which takes two sign-magnitude words and produces the sum plus a carry flag; it handles the zero-sign normalisation of REQ-015.

Verification (WIDTH=9, TERMS=9)
- REQ-030 SHALL cover: nine terms of +1, back-to-back -> out_valid one cycle after the 9th acceptance, out_data=+9 (0x00009), out_overflow=0.
- REQ-031 SHALL cover: terms +7, -7, then seven terms of +0 -> out_data=0x00000 (sign 0, no -0).
- REQ-032 SHALL cover: terms +5, -12, +3, then six terms of +0 -> sign 1, magnitude 4 (0x20004).
- REQ-033 SHALL cover: nine terms of +20000, per configuration:
  - With CONV_ACCUM_SAT_EN: out_data=0x1FFFF, out_overflow=1.
  - Without it: magnitude 48928, out_overflow=0.
- REQ-034 SHALL cover: out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_data stable; the next sum starts only after the handshake.
- REQ-035 SHALL cover: rst asserted after 4 terms -> all outputs 0 at once; then nine terms of +2 -> out_data=+18.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv_accum sign-magnitude accumulator.
package conv_pkg;

  localparam int WIDTH_DEF = 9;
  localparam int TERMS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/conv_sm_add.sv
// Combinational sign-magnitude adder: MSB is the sign, the rest the magnitude.
// The carry is reported only for same-sign adds, and a zero result is always +0.
module conv_sm_add #(
  parameter int DW = 18
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sum_o,
  output logic          carry_o
);

  localparam int MW = DW - 1;

  logic [MW:0]   add_s;
  logic [MW-1:0] mag_s;
  logic          sign_s;

  // Same signs add magnitudes; differing signs subtract the smaller from the larger.
  always_comb begin
    add_s   = {1'b0, a_i[MW-1:0]} + {1'b0, b_i[MW-1:0]};
    carry_o = 1'b0;
    mag_s   = {MW{1'b0}};
    sign_s  = 1'b0;
    if (a_i[MW] == b_i[MW]) begin
      mag_s   = add_s[MW-1:0];
      carry_o = add_s[MW];
      sign_s  = a_i[MW];
    end else if (a_i[MW-1:0] >= b_i[MW-1:0]) begin
      mag_s  = a_i[MW-1:0] - b_i[MW-1:0];
      sign_s = a_i[MW];
    end else begin
      mag_s  = b_i[MW-1:0] - a_i[MW-1:0];
      sign_s = b_i[MW];
    end
    sum_o = {sign_s & (|mag_s), mag_s};
  end

endmodule

// File: rtl/conv_accum.sv
// Accumulates TERMS sign-magnitude products per output with valid/ready handshakes.
// Define CONV_ACCUM_SAT_EN to saturate on magnitude overflow and report it on out_overflow.
module conv_accum
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TERMS = TERMS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_overflow
);

  localparam int DW = 2 * WIDTH;
  localparam int MW = DW - 1;
  localparam int CW = $clog2(TERMS + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;

  logic [DW-1:0]   sum_s;
  logic            carry_s;
  logic [DW-1:0]   new_acc_s;
  logic            ovf_evt_s;
  logic            accept_s;

  conv_sm_add #(.DW(DW)) u_add (
    .a_i     (acc_q),
    .b_i     (in_data),
    .sum_o   (sum_s),
    .carry_o (carry_s)
  );

`ifdef CONV_ACCUM_SAT_EN
  assign new_acc_s = carry_s ? {sum_s[DW-1], {MW{1'b1}}} : sum_s;
  assign ovf_evt_s = carry_s;
`else
  logic carry_unused_s;
  assign carry_unused_s = carry_s;
  assign new_acc_s      = sum_s;
  assign ovf_evt_s      = 1'b0;
`endif

  assign accept_s = in_valid && rdy_q;

  // Next-state logic; ready and valid are derived from the state being entered.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept_s) begin
          acc_d   = new_acc_s;
          ovf_d   = ovf_q | ovf_evt_s;
          count_d = count_q + CW'(1'b1);
          if (count_q == CW'(TERMS - 1)) begin
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (vld_q && out_ready) begin
          state_d = IDLE;
          count_d = {CW{1'b0}};
          acc_d   = {DW{1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
        acc_d   = {DW{1'b0}};
        ovf_d   = 1'b0;
      end
    endcase
    rdy_d = (state_d != HOLD);
    vld_d = (state_d == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      acc_q   <= {DW{1'b0}};
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = vld_q;
  assign out_data     = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_conv_accum.sv
// Scoreboard bench for conv_accum (WIDTH=9, TERMS=9): stimulus pushes expected sums,
// a monitor pops and compares on every output handshake.
module tb_conv_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_overflow;

  int n_checks = 0;
  int n_fails  = 0;
  logic [18:0] exp_q[$];

  conv_accum #(.WIDTH(9), .TERMS(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Offers one term and returns at the negedge after it was accepted.
  task automatic send(input logic [17:0] d);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_n(input logic [17:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  // Monitor: compares each completed handshake against the oldest expected sum.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_out: got 0x%0h with no expected sum", out_data);
        end else begin
          check("sum", {out_data, out_overflow}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 18'h00000;
    out_ready = 1'b1;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 18'h00000);
    check("rst_ovf", out_overflow, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);

    // Nine +1 back to back, with latency check.
    exp_q.push_back({18'h00009, 1'b0});
    send_n(18'h00001, 8);
    check("valid_before_9th", out_valid, 1'b0);
    send(18'h00001);
    in_valid = 1'b0;
    check("valid_after_9th", out_valid, 1'b1);
    check("ready_in_hold", in_ready, 1'b0);
    @(negedge clk);

    // +7, -7, then zeros: result must be +0.
    exp_q.push_back({18'h00000, 1'b0});
    send(18'h00007);
    send(18'h20007);
    send_n(18'h00000, 7);
    in_valid = 1'b0;
    @(negedge clk);

    // +5, -12, +3, then zeros: -4.
    exp_q.push_back({18'h20004, 1'b0});
    send(18'h00005);
    send(18'h2000C);
    send(18'h00003);
    send_n(18'h00000, 6);
    in_valid = 1'b0;
    @(negedge clk);

    // Nine +20000: saturates or wraps depending on build.
`ifdef CONV_ACCUM_SAT_EN
    exp_q.push_back({18'h1FFFF, 1'b1});
`else
    exp_q.push_back({18'h0BF20, 1'b0});
`endif
    send_n(18'd20000, 9);
    in_valid = 1'b0;
    @(negedge clk);

    // Back-pressure in HOLD with a pending upstream term.
    out_ready = 1'b0;
    exp_q.push_back({18'h0001B, 1'b0});
    send_n(18'h00003, 9);
    in_valid = 1'b1;
    in_data  = 18'h00001;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", in_ready, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, 18'h0001B);
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q.push_back({18'h00009, 1'b0});
    send_n(18'h00001, 9);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset mid-sum discards the partial result.
    send_n(18'h00005, 4);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 18'h00000);
    check("midrst_ovf", out_overflow, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", in_ready, 1'b1);
    exp_q.push_back({18'h00012, 1'b0});
    send_n(18'h00002, 9);
    in_valid = 1'b0;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    #2;
    check("pending_sums", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
